// File: rtl/r_type_issue_pkg.sv
// Shared decode constants, instruction field layout and FSM states for r_type_issue.
package r_type_issue_pkg;

  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_SRL    = 6'h02;
  localparam logic [5:0] F_SRA    = 6'h03;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_NOR    = 6'h27;

  // Field order matches the instruction word, op in [31:26] down to funct in [5:0].
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rinstr_t;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;

  function automatic logic is_legal(input rinstr_t i);
    logic ok;
    case (i.funct)
      F_SLL, F_SRL, F_SRA, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (i.op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/r_type_issue_regfile_2r1w.sv
// 32-entry register file: two operand read ports, one debug read port, one sync write port.
module r_type_issue_regfile_2r1w
  import r_type_issue_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  input  logic [REG_AW-1:0] ra_c,
  output logic [XLEN-1:0]   rd_a,
  output logic [XLEN-1:0]   rd_b,
  output logic [XLEN-1:0]   rd_c,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;

  // Entry 0 is forced back to zero so any write aimed at it is dropped.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd_a = mem_q[ra_a];
  assign rd_b = mem_q[ra_b];
  assign rd_c = mem_q[ra_c];

endmodule

// File: rtl/r_type_issue.sv
// R-type issue stage: decode, operand read, drive external ALU, write back.
// ISSUE_OVERLAP_EN: accept the next instruction during WB (one per 3 cycles).
module r_type_issue
  import r_type_issue_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [XLEN-1:0]   alu_rs,
  output logic [XLEN-1:0]   alu_rt,
  output logic [5:0]        alu_funct,
  output logic [4:0]        alu_shamt,
  input  logic [XLEN-1:0]   alu_rd,
  input  logic              alu_zflag,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              zflag,
  output logic              illegal,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic [XLEN-1:0]   dbg_rdata
);

  state_e            state_q, state_d;
  rinstr_t           instr_q, instr_d;
  logic [XLEN-1:0]   alu_rs_q, alu_rs_d, alu_rt_q, alu_rt_d, wb_data_q, wb_data_d;
  logic [5:0]        alu_funct_q, alu_funct_d;
  logic [4:0]        alu_shamt_q, alu_shamt_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic              zflag_q, zflag_d, illegal_q, illegal_d;

  logic [XLEN-1:0]   rf_rs, rf_rt;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic              xfer;

`ifdef ISSUE_OVERLAP_EN
  assign instr_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
  assign instr_ready = (state_q == S_IDLE);
`endif
  assign xfer = instr_valid && instr_ready;

  // Debug writes (IDLE only) and writeback (WB only) never coincide, so they share one port.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = wb_addr_q;
    rf_wd = wb_data_q;
    if (state_q == S_IDLE && dbg_we) begin
      rf_we = 1'b1;
      rf_wa = dbg_addr;
      rf_wd = dbg_wdata;
    end else if (state_q == S_WB) begin
      rf_we = 1'b1;
    end
  end

  r_type_issue_regfile_2r1w #(.NREG(NREG), .XLEN(XLEN)) u_rf (
    .clk  (clk),
    .rst  (rst),
    .ra_a (instr_q.rs),
    .ra_b (instr_q.rt),
    .ra_c (dbg_addr),
    .rd_a (rf_rs),
    .rd_b (rf_rt),
    .rd_c (dbg_rdata),
    .we   (rf_we),
    .wa   (rf_wa),
    .wd   (rf_wd)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_rs_d    = alu_rs_q;
    alu_rt_d    = alu_rt_q;
    alu_funct_d = alu_funct_q;
    alu_shamt_d = alu_shamt_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    zflag_d     = zflag_q;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: if (xfer) begin
        instr_d = rinstr_t'(instr);
        state_d = S_DECODE;
      end
      S_DECODE: if (is_legal(instr_q)) begin
        alu_rs_d    = rf_rs;
        alu_rt_d    = rf_rt;
        alu_funct_d = instr_q.funct;
        alu_shamt_d = instr_q.shamt;
        state_d     = S_EXEC;
      end else begin
        illegal_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_EXEC: begin
        wb_data_d = alu_rd;
        zflag_d   = alu_zflag;
        wb_addr_d = instr_q.rd;
        state_d   = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
`ifdef ISSUE_OVERLAP_EN
        // The WB write lands on this same edge, so DECODE already sees it.
        if (xfer) begin
          instr_d = rinstr_t'(instr);
          state_d = S_DECODE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      alu_rs_q    <= '0;
      alu_rt_q    <= '0;
      alu_funct_q <= '0;
      alu_shamt_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      zflag_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      alu_rs_q    <= alu_rs_d;
      alu_rt_q    <= alu_rt_d;
      alu_funct_q <= alu_funct_d;
      alu_shamt_q <= alu_shamt_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      zflag_q     <= zflag_d;
      illegal_q   <= illegal_d;
    end
  end

  assign alu_rs    = alu_rs_q;
  assign alu_rt    = alu_rt_q;
  assign alu_funct = alu_funct_q;
  assign alu_shamt = alu_shamt_q;
  assign wb_valid  = (state_q == S_WB);
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign zflag     = zflag_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_r_type_issue.sv
// Randomized + directed bench for r_type_issue against an in-order retirement model.
module tb_r_type_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_rs, alu_rt, alu_rd;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic        alu_zflag;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        zflag, illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;

  always #5 clk = ~clk;

  r_type_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
    .alu_rd(alu_rd), .alu_zflag(alu_zflag), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .zflag(zflag), .illegal(illegal), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (f)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = ~(a | b);
      6'h00:   r = b << sh;
      6'h02:   r = b >> sh;
      6'h03:   r = $signed(b) >>> sh;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // External combinational ALU the block drives.
  assign alu_rd    = alu_fn(alu_funct, alu_rs, alu_rt, alu_shamt);
  assign alu_zflag = (alu_rd == 32'h0);

  function automatic bit legal(input logic [31:0] w);
    return (w[31:26] == 6'h00) &&
           (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03});
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural model: register values and last retired zero flag.
  logic [31:0] mreg [32];
  logic        mz;
  logic [31:0] pend [$];
  int          pend_t [$];
  int          cyc = 0;
  logic [31:0] mon_w, mon_e;
  int          mon_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Every retire/reject event must match the oldest accepted instruction, in order.
  always @(negedge clk) begin
    if (!rst && (wb_valid || illegal)) begin
      if (pend.size() == 0) begin
        chk("spurious_evt", 32'({wb_valid, illegal}), 32'h0);
      end else begin
        mon_w = pend.pop_front();
        mon_t = pend_t.pop_front();
        if (legal(mon_w)) begin
          mon_e = alu_fn(mon_w[5:0], mreg[mon_w[25:21]], mreg[mon_w[20:16]], mon_w[10:6]);
          chk("evt_kind", 32'({wb_valid, illegal}), 32'h2);
          chk("wb_latency", 32'(cyc - mon_t), 32'd2);
          chk("wb_addr", 32'(wb_addr), 32'(mon_w[15:11]));
          chk("wb_data", wb_data, mon_e);
          chk("zflag", 32'(zflag), 32'(mon_e == 32'h0));
          if (mon_w[15:11] != 5'd0) mreg[mon_w[15:11]] = mon_e;
          mz = (mon_e == 32'h0);
        end else begin
          chk("evt_kind", 32'({wb_valid, illegal}), 32'h1);
          chk("ill_latency", 32'(cyc - mon_t), 32'd1);
          chk("ill_zflag_hold", 32'(zflag), 32'(mz));
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the transfer edge (DECODE cycle).
  task automatic send(input logic [31:0] w, output int tc);
    int n;
    n = 0;
    tc = -1;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        chk("ready_timeout", 32'(instr_ready), 32'h1);
        instr_valid = 1'b0;
        return;
      end
    end
    tc = cyc + 1;
    pend.push_back(w);
    pend_t.push_back(tc);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(pend.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
    if (a != 5'd0) mreg[a] = d;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk(tag, dbg_rdata, mreg[i]);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] lf [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
    logic [5:0] op, fn;
    op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
    fn = ($urandom_range(0, 6) == 0) ? 6'($urandom_range(0, 63)) : lf[$urandom_range(0, 8)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), fn};
  endfunction

  int tc, tprev;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mz = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_ready", 32'(instr_ready), 32'h1);
    chk("rst_alu_rs", alu_rs, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // add $3,$1,$2 with 5+3; busy for DECODE/EXEC (and WB unless overlapped).
    dbg_wr(5'd1, 32'd5);
    dbg_wr(5'd2, 32'd3);
    send(32'h0022_1820, tc);
    chk("busy_decode", 32'(instr_ready), 32'h0);
    @(negedge clk);
    chk("busy_exec", 32'(instr_ready), 32'h0);
    @(negedge clk);
`ifdef ISSUE_OVERLAP_EN
    chk("ready_wb", 32'(instr_ready), 32'h1);
`else
    chk("busy_wb", 32'(instr_ready), 32'h0);
`endif
    chk("add_wb_valid", 32'(wb_valid), 32'h1);
    chk("add_result", wb_data, 32'd8);
    drain();
    dbg_addr = 5'd3; #1;
    chk("add_dbg_rd3", dbg_rdata, 32'd8);
    @(negedge clk);

    // sub $4,$1,$1 -> zero result sets zflag.
    send(32'h0021_2022, tc);
    repeat (2) @(negedge clk);
    chk("sub_result", wb_data, 32'h0);
    chk("sub_zflag", 32'(zflag), 32'h1);
    drain();

    // sra $5,$6,4 on 0x80000000.
    dbg_wr(5'd6, 32'h8000_0000);
    send(32'h0006_2903, tc);
    repeat (2) @(negedge clk);
    chk("sra_result", wb_data, 32'hF800_0000);
    drain();

    // Illegal op and illegal funct: one pulse, no writeback, ready again.
    send(32'h2022_1820, tc);
    @(negedge clk);
    chk("ill_op_pulse", 32'(illegal), 32'h1);
    chk("ill_op_ready", 32'(instr_ready), 32'h1);
    @(negedge clk);
    chk("ill_op_once", 32'(illegal), 32'h0);
    send(32'h0022_182A, tc);
    @(negedge clk);
    chk("ill_fn_pulse", 32'(illegal), 32'h1);
    drain();
    check_regs("ill_regs");

    // Destination 0 still pulses wb_valid but reg0 stays zero, debug write to 0 dropped.
    send(32'h0022_0020, tc);
    repeat (2) @(negedge clk);
    chk("r0_wb_valid", 32'(wb_valid), 32'h1);
    drain();
    dbg_wr(5'd0, 32'hDEAD_BEEF);
    check_regs("r0_regs");

    // Debug write in the transfer cycle is visible to that instruction: add $7,$1,$1.
    dbg_we = 1'b1; dbg_addr = 5'd1; dbg_wdata = 32'd100;
    mreg[1] = 32'd100;
    send(32'h0021_3820, tc);
    dbg_we = 1'b0;
    drain();

    // Valid held high: dependent chain, fixed spacing between transfers.
    tprev = -1;
    for (int k = 0; k < 4; k++) begin
      send({6'h00, 5'(8 + k), 5'd1, 5'(9 + k), 5'd0, 6'h20}, tc);
      if (tprev >= 0) begin
`ifdef ISSUE_OVERLAP_EN
        chk("stream_spacing", 32'(tc - tprev), 32'd3);
`else
        chk("stream_spacing", 32'(tc - tprev), 32'd4);
`endif
      end
      tprev = tc;
    end
    drain();
    check_regs("stream_regs");

    // Randomized mix of instructions, gaps and debug writes.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        drain();
        dbg_wr(5'($urandom_range(0, 7)), $urandom);
      end else begin
        send(rand_word(), tc);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    check_regs("rand_regs");

    // Reset in EXEC aborts the instruction with no pulses.
    dbg_wr(5'd1, 32'd7);
    send(32'h0021_1820, tc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_rs", alu_rs, 32'h0);
    chk("mid_rst_alu_rt", alu_rt, 32'h0);
    chk("mid_rst_funct", 32'(alu_funct), 32'h0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("mid_rst_zflag", 32'(zflag), 32'h0);
    chk("mid_rst_ready", 32'(instr_ready), 32'h1);
    pend.delete();
    pend_t.delete();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_wb", 32'(wb_valid), 32'h0);
    end
    check_regs("post_rst_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_type_issue.md
Name: r_type_issue

Overview:
- Producer side of the ALU operand interface: accepts 32-bit MIPS R-type instruction words over a valid/ready handshake.
- Decodes the rs/rt/rd/shamt/funct fields and reads operands from an internal 32x32 register file.
- Drives the combinational ALU's rs/rt/funct/shamt inputs, captures its rd/zflag outputs, and writes the result back.
- Sits between instruction fetch and the ALU in the core datapath.

Parameters:
- NREG, 32, register file depth (fixed 32; index width 5).
- XLEN, 32, datapath width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction word present
- instr  input  32  instruction word: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- instr_ready  output  1  block can accept an instruction this cycle
- alu_rs  output  32  operand A to ALU
- alu_rt  output  32  operand B to ALU
- alu_funct  output  6  function code to ALU
- alu_shamt  output  5  shift amount to ALU
- alu_rd  input  32  ALU result
- alu_zflag  input  1  ALU zero flag
- wb_valid  output  1  one-cycle pulse: instruction retired
- wb_addr  output  5  destination register of retired instruction
- wb_data  output  32  value written
- zflag  output  1  registered zero flag of last retired instruction
- illegal  output  1  one-cycle pulse: rejected instruction
- dbg_we  input  1  debug register write, honoured only in IDLE
- dbg_addr  input  5  debug read/write index
- dbg_wdata  input  32  debug write data
- dbg_rdata  output  32  combinational read of reg[dbg_addr]; 0 for index 0

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE; every register file entry 0; alu_rs/alu_rt/wb_data 0; alu_funct/alu_shamt/wb_addr 0; wb_valid, illegal and zflag 0.
- instr_ready = 1 only in IDLE.
- Transfer occurs when instr_valid && instr_ready at a rising edge.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: on transfer, latch instr and go to DECODE. Otherwise stay.
  - DECODE: check legality. Legal means op == 0 and funct is in {100000, 100010, 100100, 100101, 100110, 100111, 000000, 000010, 000011}.
    - Illegal: pulse illegal for one cycle (visible in the next cycle) and return to IDLE. No writeback, zflag unchanged.
    - Legal: register reg[rs] -> alu_rs, reg[rt] -> alu_rt, funct -> alu_funct, shamt -> alu_shamt. Go to EXEC.
  - EXEC: ALU outputs settle combinationally from the registered operands. Capture alu_rd -> wb_data, alu_zflag -> zflag, rd field -> wb_addr. Go to WB.
  - WB: wb_valid = 1 for exactly this cycle. At the end of the cycle, write reg[wb_addr] = wb_data unless wb_addr == 0. Go to IDLE.
- Register 0 always reads 0; writes to index 0 (including debug writes) are dropped, but wb_valid still pulses.
- Latency: transfer at edge N -> wb_valid high during cycle N+3. Throughput: one instruction per 4 cycles.
- alu_* outputs hold their last value outside EXEC.
- dbg_we outside IDLE is ignored. dbg_we in IDLE in the same cycle as an instruction transfer: the debug write is applied first and the instruction sees the new value.
- Reset mid-operation aborts the instruction with no writeback and no pulses.

Optional Feature:
- Macro: ISSUE_OVERLAP_EN.
- Defined: instr_ready is also 1 in WB; a transfer in WB goes directly to DECODE. The WB register write lands at that same edge, so DECODE reads the updated value with no bypass logic. Throughput: one instruction per 3 cycles.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package: op/funct code constants (same nine funct encodings the ALU decodes), instruction field bit ranges, FSM state enum.
- One sub-module, regfile_2r1w: 32x32, two combinational read ports, one synchronous write port, index-0 hardwired to zero. The debug read uses a third read port or shares one while in IDLE.

Test Plan:
- Reset, then dbg_we reg1=5 and reg2=3, then issue add $3,$1,$2 (0x00221820) -> wb_valid at N+3, wb_addr=3, wb_data=8, zflag=0; dbg_rdata(3)=8.
- sub $4,$1,$1 (0x00212022) with reg1=5 -> wb_data=0, zflag=1.
- sra $5,$0,$6 with shamt=4, reg6=0x80000000 (0x00062903 with shamt=4) -> wb_data=0xF8000000.
- Op=0x08 word, or funct=0x2A -> illegal pulses once; wb_valid stays 0; register file unchanged; instr_ready high again by N+2.
- add $0,$1,$2 -> wb_valid pulses, reg0 still reads 0. Hold instr_valid high continuously -> instr_ready low in DECODE/EXEC/WB; no transfer lost or duplicated.
- Assert rst during EXEC -> all outputs 0 immediately, FSM in IDLE, no wb_valid. Under ISSUE_OVERLAP_EN, back-to-back dependent adds retire 3 cycles apart with correct chained results.
